// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the I/D physical-memory arbiter: FSM states, owner encoding
// and the round-robin pick used when both caches are pending.
package pmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_I_BUSY  = 2'd1,
    ARB_D_BUSY  = 2'd2,
    ARB_RECOVER = 2'd3
  } pmem_arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } pmem_arb_owner_t;

  // Only meaningful when at least one requester is pending.
  function automatic pmem_arb_owner_t arb_pick(input logic            i_pend,
                                               input logic            d_pend,
                                               input pmem_arb_owner_t last);
    pmem_arb_owner_t win;
    if (i_pend && d_pend) begin
      win = (last == OWNER_I) ? OWNER_D : OWNER_I;
    end else if (i_pend) begin
      win = OWNER_I;
    end else begin
      win = OWNER_D;
    end
    return win;
  endfunction

endpackage

// File: rtl/pmem_arbiter.sv
// Arbitrates the single physical-memory line port between the I-cache and the
// D-cache; the memory request is fully registered, the response is routed back.
module pmem_arbiter
  import pmem_arbiter_pkg::*;
#(
  parameter int s_line = 256
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              i_pmem_read,
  input  logic [31:0]       i_pmem_address,
  output logic              i_pmem_resp,
  output logic [s_line-1:0] i_pmem_rdata,

  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [31:0]       d_pmem_address,
  input  logic [s_line-1:0] d_pmem_wdata,
  output logic              d_pmem_resp,
  output logic [s_line-1:0] d_pmem_rdata,

  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  output logic [s_line-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [s_line-1:0] pmem_rdata
);

  pmem_arb_state_t   state_q, state_d;
  pmem_arb_owner_t   last_grant_q, last_grant_d;
  logic              pmem_read_q, pmem_read_d;
  logic              pmem_write_q, pmem_write_d;
  logic [31:0]       pmem_address_q, pmem_address_d;
  logic [s_line-1:0] pmem_wdata_q, pmem_wdata_d;

  logic              i_pend;
  logic              d_pend;
  pmem_arb_owner_t   win;

  // Stage boundary: arbiter state and the registered memory request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ARB_IDLE;
      last_grant_q   <= OWNER_D;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    pmem_read_d    = pmem_read_q;
    pmem_write_d   = pmem_write_q;
    pmem_address_d = pmem_address_q;
    pmem_wdata_d   = pmem_wdata_q;
    i_pmem_resp    = 1'b0;
    i_pmem_rdata   = '0;
    d_pmem_resp    = 1'b0;
    d_pmem_rdata   = '0;
    i_pend         = i_pmem_read;
    d_pend         = d_pmem_read | d_pmem_write;
    win            = arb_pick(i_pend, d_pend, last_grant_q);

    unique case (state_q)
      ARB_IDLE: begin
        if (i_pend || d_pend) begin
          last_grant_d = win;
          if (win == OWNER_I) begin
            pmem_address_d = i_pmem_address;
            pmem_read_d    = 1'b1;
            pmem_write_d   = 1'b0;
            state_d        = ARB_I_BUSY;
          end else begin
            // read+write together from the D-cache is resolved as a write
            pmem_address_d = d_pmem_address;
            pmem_wdata_d   = d_pmem_wdata;
            pmem_write_d   = d_pmem_write;
            pmem_read_d    = ~d_pmem_write;
            state_d        = ARB_D_BUSY;
          end
        end
      end

      ARB_I_BUSY: begin
        i_pmem_resp  = pmem_resp;
        i_pmem_rdata = pmem_resp ? pmem_rdata : '0;
        if (pmem_resp) begin
          pmem_read_d  = 1'b0;
          pmem_write_d = 1'b0;
          state_d      = ARB_RECOVER;
        end
      end

      ARB_D_BUSY: begin
        d_pmem_resp  = pmem_resp;
        d_pmem_rdata = pmem_resp ? pmem_rdata : '0;
        if (pmem_resp) begin
          pmem_read_d  = 1'b0;
          pmem_write_d = 1'b0;
          state_d      = ARB_RECOVER;
        end
      end

      // Caches still hold their request for this cycle; it must not re-grant.
      ARB_RECOVER: begin
        state_d = ARB_IDLE;
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;

endmodule
